// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshake, backpressure and bubble
// collapsing. Stage 1 registers operands and the decoded op, stage 2 registers
// the computed result and flags, stages 3..PIPE_STAGES are delay registers.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     input handshake
//   i_sel_op, i_op_a/b    operation code and operands
//   o_valid / i_ready     output handshake
//   o_res, o_zero,
//   o_carry, o_ovf        result and flags (held stable while stalled)
module alu_pipe #(
  parameter int unsigned BITS        = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_sel_op,
  input  logic [BITS-1:0] i_op_a,
  input  logic [BITS-1:0] i_op_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_res,
  output logic            o_zero,
  output logic            o_carry,
  output logic            o_ovf
);

  localparam int unsigned SHW = $clog2(BITS);
  localparam int unsigned N   = PIPE_STAGES;
  localparam int unsigned PW  = BITS + 3;  // {res, zero, carry, ovf}

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_AND  = 5'h03,
    OP_OR   = 5'h04,
    OP_XOR  = 5'h05,
    OP_SLT  = 5'h06,
    OP_SLTU = 5'h07,
    OP_SLL  = 5'h08,
    OP_SRL  = 5'h09,
    OP_SRA  = 5'h0A,
    OP_CPA  = 5'h0B,
    OP_CPB  = 5'h0C
  } op_e;

  // Stage 1
  op_e             r_op;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  // Stages 2..N: packed result/flags
  logic [PW-1:0]   r_pl [2:N];
  logic [N:1]      r_v;

  logic [N:1]      w_move;
  logic            w_acc;
  op_e             w_op;
  logic [BITS:0]   w_sum;
  logic [BITS:0]   w_dif;
  logic [SHW-1:0]  w_shamt;
  logic [BITS-1:0] w_res;
  logic            w_z;
  logic            w_c;
  logic            w_o;
  logic [PW-1:0]   w_pl;

  // A stage is blocked only if it and every stage after it is full while the
  // output is stalled; computing this front-to-back avoids a combinational
  // chain through w_move itself.
  always_comb begin : p_move
    logic l_blk;
    w_move = '0;
    l_blk  = !i_ready;
    for (int unsigned s = N; s >= 1; s--) begin
      l_blk     = l_blk && r_v[s];
      w_move[s] = r_v[s] && !l_blk;
    end
  end

  assign o_ready = !i_rst && (!r_v[1] || w_move[1]);
  assign w_acc   = i_valid && o_ready;

  always_comb begin
    w_op = OP_NOP;
    if (i_sel_op >= 5'h01 && i_sel_op <= 5'h0C) w_op = op_e'(i_sel_op);
  end

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif   = {1'b0, r_a} - {1'b0, r_b};
  assign w_shamt = r_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[BITS-1:0];
        w_c   = w_sum[BITS];
        w_o   = (r_a[BITS-1] == r_b[BITS-1]) && (w_sum[BITS-1] != r_a[BITS-1]);
      end
      OP_SUB: begin
        w_res = w_dif[BITS-1:0];
        w_c   = w_dif[BITS];  // borrow: set iff a < b unsigned
        w_o   = (r_a[BITS-1] != r_b[BITS-1]) && (w_dif[BITS-1] != r_a[BITS-1]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SLT:  w_res[0] = $signed(r_a) < $signed(r_b);
      OP_SLTU: w_res[0] = r_a < r_b;
      OP_SLL:  w_res = r_a << w_shamt;
      OP_SRL:  w_res = r_a >> w_shamt;
      OP_SRA:  w_res = $unsigned($signed(r_a) >>> w_shamt);
      OP_CPA:  w_res = r_a;
      OP_CPB:  w_res = r_b;
      default: ;
    endcase
    w_z = (w_res == '0);
  end

  assign w_pl = {w_res, w_z, w_c, w_o};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v  <= '0;
      r_op <= OP_NOP;
      r_a  <= '0;
      r_b  <= '0;
      for (int unsigned s = 2; s <= N; s++) r_pl[s] <= '0;
    end else begin
      if (w_acc) begin
        r_v[1] <= 1'b1;
        r_op   <= w_op;
        r_a    <= i_op_a;
        r_b    <= i_op_b;
      end else if (w_move[1]) begin
        r_v[1] <= 1'b0;
      end

      if (w_move[1]) begin
        r_v[2]  <= 1'b1;
        r_pl[2] <= w_pl;
      end else if (w_move[2]) begin
        r_v[2]  <= 1'b0;
      end

      for (int unsigned s = 3; s <= N; s++) begin
        if (w_move[s-1]) begin
          r_v[s]  <= 1'b1;
          r_pl[s] <= r_pl[s-1];
        end else if (w_move[s]) begin
          r_v[s]  <= 1'b0;
        end
      end
    end
  end

  assign o_valid                          = r_v[N];
  assign {o_res, o_zero, o_carry, o_ovf}  = r_pl[N];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: a PIPE_STAGES=2 instance for the
// op table, stall/stream, idle and reset cases, and a PIPE_STAGES=4 instance
// for latency and bubble collapse.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // Instance A (2 stages)
  logic       a_valid, a_oready, a_sel_dummy;
  logic [4:0] a_sel;
  logic [7:0] a_opa, a_opb;
  logic       a_ovalid, a_iready;
  logic [7:0] a_res;
  logic       a_zero, a_carry, a_ovf;
  // Instance B (4 stages)
  logic       b_valid, b_oready;
  logic [4:0] b_sel;
  logic [7:0] b_opa, b_opb;
  logic       b_ovalid, b_iready;
  logic [7:0] b_res;
  logic       b_zero, b_carry, b_ovf;

  alu_pipe #(.BITS(8), .PIPE_STAGES(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_oready),
    .i_sel_op(a_sel), .i_op_a(a_opa), .i_op_b(a_opb),
    .o_valid(a_ovalid), .i_ready(a_iready),
    .o_res(a_res), .o_zero(a_zero), .o_carry(a_carry), .o_ovf(a_ovf)
  );

  alu_pipe #(.BITS(8), .PIPE_STAGES(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_oready),
    .i_sel_op(b_sel), .i_op_a(b_opa), .i_op_b(b_opb),
    .o_valid(b_ovalid), .i_ready(b_iready),
    .o_res(b_res), .o_zero(b_zero), .o_carry(b_carry), .o_ovf(b_ovf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through the 2-stage instance with i_ready high; zco = {zero,carry,ovf}
  task automatic op1(input string tag, input logic [4:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] res, input logic [2:0] zco);
    a_valid = 1'b1; a_sel = op; a_opa = a; a_opb = b; a_iready = 1'b1;
    tick();
    a_valid = 1'b0;
    chk({tag, " early"}, a_ovalid, 0);
    tick();
    chk({tag, " valid"}, a_ovalid, 1);
    chk(tag, {a_res, a_zero, a_carry, a_ovf}, {res, zco});
  endtask

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int  cnt, nxt, rel;
  logic held;
  logic [8:0] hval;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_sel = 0; a_opa = 0; a_opb = 0; a_iready = 1; a_sel_dummy = 0;
    b_valid = 0; b_sel = 0; b_opa = 0; b_opb = 0; b_iready = 0;
    tick(); tick();
    chk("rst valid", a_ovalid, 0);
    chk("rst outs", {a_res, a_zero, a_carry, a_ovf}, 0);
    chk("rst ready", a_oready, 0);
    chk("rst b valid", b_ovalid, 0);
    rst = 1'b0; #1;
    chk("post rst ready", a_oready, 1);

    // Op table
    op1("add F0+20", 5'h01, 8'hF0, 8'h20, 8'h10, 3'b010);
    op1("add 7F+01", 5'h01, 8'h7F, 8'h01, 8'h80, 3'b001);
    op1("sub 80-01", 5'h02, 8'h80, 8'h01, 8'h7F, 3'b001);
    op1("sub 01-02", 5'h02, 8'h01, 8'h02, 8'hFF, 3'b010);
    op1("sub 05-05", 5'h02, 8'h05, 8'h05, 8'h00, 3'b100);
    op1("and",       5'h03, 8'hF0, 8'h3C, 8'h30, 3'b000);
    op1("or",        5'h04, 8'hF0, 8'h3C, 8'hFC, 3'b000);
    op1("xor",       5'h05, 8'hF0, 8'h3C, 8'hCC, 3'b000);
    op1("sra",       5'h0A, 8'h80, 8'h0B, 8'hF0, 3'b000);
    op1("srl",       5'h09, 8'h80, 8'h0B, 8'h10, 3'b000);
    op1("sll",       5'h08, 8'h80, 8'h0B, 8'h00, 3'b100);
    op1("slt",       5'h06, 8'hFF, 8'h01, 8'h01, 3'b000);
    op1("sltu",      5'h07, 8'hFF, 8'h01, 8'h00, 3'b100);
    op1("cpa",       5'h0B, 8'hF0, 8'h3C, 8'hF0, 3'b000);
    op1("cpb",       5'h0C, 8'hF0, 8'h3C, 8'h3C, 3'b000);
    op1("nop 1F",    5'h1F, 8'h12, 8'h34, 8'h00, 3'b100);
    op1("nop 0D",    5'h0D, 8'hFF, 8'hFF, 8'h00, 3'b100);
    tick();
    chk("table drained", a_ovalid, 0);

    // Stream of 10 adds with a 5-cycle stall
    cnt = 0; nxt = 0; rel = 0; held = 1'b0; hval = '0;
    a_sel = 5'h01;
    for (int j = 0; j < 40 && rel < 10; j++) begin
      a_iready = !(j >= 3 && j < 8);
      a_valid  = (nxt < 10);
      a_opa    = 8'(nxt * 37);
      a_opb    = 8'(nxt * 23 + 5);
      #1;
      chk("stream ready", a_oready, (cnt < 2) || a_iready);
      if (held) begin
        chk("held valid", a_ovalid, 1);
        chk("held data", {a_carry, a_res}, hval);
      end
      held = a_ovalid && !a_iready;
      hval = {a_carry, a_res};
      if (a_ovalid && a_iready) begin
        chk("stream nonempty", qa.size() > 0, 1);
        if (qa.size() > 0) chk("stream data", {a_carry, a_res}, qa.pop_front());
        rel++; cnt--;
      end
      if (a_valid && a_oready) begin
        qa.push_back({1'b0, a_opa} + {1'b0, a_opb});
        nxt++; cnt++;
      end
      tick();
    end
    a_valid = 1'b0; #1;
    chk("stream count", rel, 10);
    chk("stream drained", a_ovalid, 0);

    // Single op then idle, output stalled
    a_iready = 1'b0; a_valid = 1'b1; a_opa = 8'h01; a_opb = 8'h02;
    tick();
    a_valid = 1'b0; #1;
    chk("idle ready s1", a_oready, 1);
    chk("idle early", a_ovalid, 0);
    tick();
    chk("idle out valid", a_ovalid, 1);
    chk("idle out res", a_res, 8'h03);
    chk("idle ready", a_oready, 1);
    tick();
    chk("idle hold res", a_res, 8'h03);
    chk("idle ready2", a_oready, 1);
    a_valid = 1'b1; a_opa = 8'h04; a_opb = 8'h04;
    tick();
    a_valid = 1'b0; #1;
    chk("idle full ready", a_oready, 0);
    chk("idle hold res2", a_res, 8'h03);
    a_iready = 1'b1; #1;
    chk("idle release ready", a_oready, 1);
    tick();
    chk("idle second", {a_ovalid, a_res}, {1'b1, 8'h08});
    tick();
    chk("idle drained", a_ovalid, 0);

    // Reset with two ops in flight
    a_iready = 1'b0; a_valid = 1'b1; a_opa = 8'h10; a_opb = 8'h20;
    tick();
    a_opa = 8'h30; a_opb = 8'h40;
    tick();
    a_valid = 1'b0; #1;
    chk("pre-rst full", a_oready, 0);
    rst = 1'b1; #1;
    chk("rst ready low", a_oready, 0);
    tick();
    chk("midrst valid", a_ovalid, 0);
    chk("midrst outs", {a_res, a_zero, a_carry, a_ovf}, 0);
    rst = 1'b0; #1;
    chk("midrst ready", a_oready, 1);
    a_iready = 1'b1;
    tick();
    chk("discarded 1", a_ovalid, 0);
    tick();
    chk("discarded 2", a_ovalid, 0);

    // 4-stage instance: latency and bubble collapse
    cnt = 0; nxt = 0; rel = 0;
    b_sel = 5'h01;
    for (int j = 0; j < 40 && rel < 5; j++) begin
      b_iready = (j >= 12);
      b_valid  = (j == 0) || (j >= 4 && nxt < 5);
      b_opa    = 8'(nxt * 16 + 1);
      b_opb    = 8'(nxt);
      #1;
      chk("b ready", b_oready, (cnt < 4) || b_iready);
      if (j <= 4) chk("b latency", b_ovalid, j >= 4);
      if (b_ovalid && b_iready) begin
        chk("b nonempty", qb.size() > 0, 1);
        if (qb.size() > 0) chk("b data", {b_carry, b_res}, qb.pop_front());
        rel++; cnt--;
      end
      if (b_valid && b_oready) begin
        qb.push_back({1'b0, b_opa} + {1'b0, b_opb});
        nxt++; cnt++;
      end
      tick();
    end
    b_valid = 1'b0; #1;
    chk("b count", rel, 5);
    chk("b drained", b_ovalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-issue ALU wrapper.
- Accepts one operation per cycle over a valid/ready handshake and carries it through a configurable-depth pipeline with backpressure and bubble collapsing.
- Returns the result plus zero/carry/overflow flags.
- Sits between an issue stage and a writeback stage that may stall.

Parameters:
- BITS, 8, operand and result width (>= 2).
- PIPE_STAGES, 2, total register stages from input to output (>= 2).

Ports:
- i_clk  in  1  clock, all logic on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  block can accept an input this cycle.
- i_sel_op  in  5  operation select code.
- i_op_a  in  BITS  operand A.
- i_op_b  in  BITS  operand B.
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts the result this cycle.
- o_res  out  BITS  result.
- o_zero  out  1  o_res == 0.
- o_carry  out  1  carry out (add) or borrow (sub).
- o_ovf  out  1  signed overflow (add/sub).

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Op codes:
  - 0x01 add, 0x02 sub, 0x03 and, 0x04 or, 0x05 xor.
  - 0x06 slt (signed a<b -> 1 else 0), 0x07 sltu (unsigned).
  - 0x08 sll, 0x09 srl, 0x0A sra (arithmetic).
  - 0x0B cpa (res=a), 0x0C cpb (res=b).
  - Every other code, including 0x00 and 0x0D-0x1F: nop, res=0.
- Shift amount = i_op_b[$clog2(BITS)-1:0]; upper bits of B are ignored.
- Arithmetic is modulo 2^BITS.
  - add: carry = bit BITS of the (BITS+1)-bit sum.
  - sub: carry = borrow (1 iff a<b unsigned).
  - ovf: set on add/sub when the operand signs and the result sign indicate signed overflow.
  - carry and ovf are 0 for all other ops.
  - zero is valid for every op, including nop (zero=1).
- Stage 1 registers the operands and the decoded op on an accepted transfer (i_valid && o_ready).
- Stage 2 registers the computed result and flags. Stages 3..PIPE_STAGES are delay registers.
- Each stage has a valid bit. A stage loads when it is empty, or when its content moves forward in the same cycle.
- Output stage content moves forward when o_valid && i_ready.
- o_ready = !i_rst && (stage 1 empty || stage 1 moves forward).
- Latency: data accepted on edge k is presented with o_valid=1 during the cycle after edge k+PIPE_STAGES-1, provided there is no stall.
- Full throughput of 1 op/cycle when i_ready is held high.
- Backpressure: when i_ready=0 while o_valid=1, the output stage holds o_res, o_zero, o_carry and o_ovf stable.
  - Upstream stages keep advancing into empty slots (bubbles collapse).
  - o_ready drops only when all stages are full.
- No loss, duplication or reordering of operations under any i_valid/i_ready pattern.
- Simultaneous accept at the input and release at the output in a full pipeline: both occur; occupancy is unchanged.
- While o_valid=0, o_res and the flags are don't-care for the consumer. The implementation drives 0 after reset until the first result.
- Reset, including mid-operation:
  - On the edge where i_rst=1, all valid bits clear and all data/flag registers go to 0.
  - In-flight ops are discarded.
  - o_valid=0 and o_res/o_zero/o_carry/o_ovf = 0 from the cycle after that edge.
  - o_ready=0 while i_rst=1, and 1 in the first cycle after reset deasserts.
- Inputs are ignored when i_valid=0 or o_ready=0.

Test Plan:
- BITS=8, PIPE_STAGES=2, i_ready=1: add 0xF0+0x20 accepted at edge k -> o_valid=1 after edge k+1; res=0x10, carry=1, ovf=0, zero=0.
- sub 0x80-0x01 -> res=0x7F, ovf=1, carry=0. sub 0x01-0x02 -> res=0xFF, carry=1, ovf=0. sub 0x05-0x05 -> res=0x00, zero=1.
- Shifts with a=0x80, b=0x0B (amount 3): sra -> 0xF0, srl -> 0x10, sll -> 0x00 with zero=1. slt a=0xFF, b=0x01 -> 1; sltu with the same operands -> 0.
- Back-to-back stream of 10 adds, i_ready held low for 5 cycles mid-stream:
  - The pipeline fills and o_ready=0 only once all stages are valid.
  - Held output stays stable.
  - All 10 results emerge in order with no duplicates.
- Single op followed by idle input, with i_ready=0: o_ready stays 1 until the second op fills stage 1 behind the held output. PIPE_STAGES=4 run shows latency of 4 cycles and bubble collapse.
- Reset asserted with 2 ops in flight -> o_valid=0 and outputs 0 the next cycle, and o_ready=1 the first cycle after reset. Invalid code 0x1F -> res=0, zero=1, carry=0, ovf=0.
